onchip_memory_dp_ctrl: RTL and testbench
========================================

// Module: onchip_memory_dp_ctrl
// PURPOSE
//  Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2) for the PCIe/Qsys fabric.
//  Adds a configurable read pipeline with readdatavalid, per-byte write collision arbitration, and a
//  post-reset memory-clear sequencer that holds waitrequest until the array is initialised.
// PARAMETERS
//  DATA_W        128       word width in bits; must be a multiple of 8
//  DEPTH         32768     number of words; need not be a power of two
//  ADDR_W        15        address width, = clog2(DEPTH)
//  READ_LATENCY  1         1 or 2 cycles from read accept to readdatavalid; other values are an elaboration error
//  INIT_CLEAR    1         1: sweep the array with INIT_VALUE after reset; 0: skip the sweep
//  INIT_VALUE    0         DATA_W-bit fill pattern written during the sweep
// PORTS
//  clk               in   1          single clock; all logic on the rising edge
//  reset_n           in   1          synchronous, active-low reset
//  clken             in   1          global clock enable; low freezes all state
//  s{1,2}_address    in   ADDR_W     word address
//  s{1,2}_byteenable in   DATA_W/8   per-byte write enable
//  s{1,2}_chipselect in   1          port select
//  s{1,2}_read       in   1          read request
//  s{1,2}_write      in   1          write request
//  s{1,2}_writedata  in   DATA_W     write data
//  s{1,2}_readdata   out  DATA_W     read data; valid only while readdatavalid is high
//  s{1,2}_readdatavalid out 1        one-cycle pulse per accepted read
//  s{1,2}_waitrequest   out 1        high while INIT is running or clken is low
//  init_done         out  1          high once the sweep has finished or been skipped
// BEHAVIOUR
//  Reset (reset_n low at a clk edge): readdata=0, readdatavalid=0, waitrequest=1, init_done=0 on both ports.
//    The read pipeline is flushed; pending reads are discarded and produce no readdatavalid.
//  FSM, RESET -> INIT -> RUN:
//    RESET is one cycle after reset_n rises. It goes to INIT when INIT_CLEAR=1, otherwise to RUN.
//    INIT writes INIT_VALUE to addresses 0..DEPTH-1, one word per cycle in which clken=1.
//      The counter does not advance when clken=0. INIT goes to RUN on the cycle after address DEPTH-1 is written.
//    In RUN: init_done=1 and waitrequest=~clken.
//    reset_n low in any state returns the FSM to RESET; a sweep in progress restarts from address 0.
//  Accept conditions:
//    read accepted  = chipselect & read & ~write & ~waitrequest
//    write accepted = chipselect & write & ~waitrequest
//    read and write both high on one port: the write is performed, the read is ignored, no readdatavalid.
//  Read latency:
//    readdatavalid pulses exactly READ_LATENCY enabled cycles after accept. clken=0 cycles do not count.
//    readdatavalid is forced 0 while clken=0; a frozen pending result is emitted after clken returns.
//    Back-to-back reads sustain one result per cycle per port, delivered in order.
//  Read-during-write returns OLD data, on the same port and across ports.
//  Collision (both ports write the same address in the same cycle), per byte lane:
//    s1 wins on lanes enabled on both ports; s2 is written on lanes enabled only by s2.
//  Out-of-range address (>= DEPTH): writes are dropped; reads return 0 with a normal readdatavalid.
//  Byteenable all-zero write: no storage change; the write still counts as accepted.
// TESTING
//  T1 INIT_CLEAR=1, DEPTH=16, INIT_VALUE=32'hA5A5A5A5, DATA_W=32: release reset_n -> waitrequest high
//     for 1+16 cycles, init_done rises on cycle 18; a read of address 7 returns 32'hA5A5A5A5.
//  T2 READ_LATENCY=2: s1 reads addresses 0,1,2 on consecutive cycles after writes of 11,22,33 ->
//     readdatavalid high on cycles +2,+3,+4 with data 11,22,33.
//  T3 Collision: s1 writes 32'h11111111 with be=4'b0011 and s2 writes 32'h22222222 with be=4'b0110,
//     both to address 5, over an initial value of 0 -> readback is 32'h00221111.
//  T4 clken=0 for 3 cycles one cycle after a read accept (READ_LATENCY=2) -> readdatavalid stays 0
//     during the freeze and pulses one cycle after clken returns; waitrequest is high during the freeze.
//  T5 Assert reset_n low while the sweep is at address 9 -> sweep restarts from 0, init_done=0,
//     full DEPTH-cycle sweep repeats; a pending read issued before the reset never produces readdatavalid.
//  T6 DEPTH=12, write then read address 13 -> storage unchanged, readdata=0, readdatavalid pulses.

Source files
------------

// File: rtl/onchip_memory_dp_ctrl_if.sv
// Avalon-MM slave port bundle for onchip_memory_dp_ctrl.
//   address/byteenable/chipselect/read/write/writedata : master -> slave
//   readdata/readdatavalid/waitrequest                  : slave  -> master
interface onchip_memory_dp_ctrl_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 15
);
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                chipselect;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;
   logic                waitrequest;

   modport master (
      output address, byteenable, chipselect, read, write, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, byteenable, chipselect, read, write, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/onchip_memory_dp_ctrl.sv
// True-dual-port on-chip RAM with two Avalon-MM slave ports.
//   clk, reset_n (sync, active low), clken (global enable, low freezes state)
//   s1, s2     : Avalon-MM slave ports (onchip_memory_dp_ctrl_if.slave)
//   init_done  : high once the post-reset clear sweep has finished or been skipped
// Reads return old data on read-during-write; on a same-address write
// collision s1 owns every byte lane it enables, s2 gets the rest of its lanes.
// Out-of-range addresses drop writes and read back as zero.

// Per-port read return pipeline: READ_LATENCY enabled cycles from accept to
// readdatavalid. Valid is masked while clken is low so a frozen result is
// emitted only once the clock enable returns.
module onchip_memory_dp_rdpipe #(
   parameter int DATA_W = 128,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clken,
   input  logic              accept,
   input  logic [DATA_W-1:0] rd_word,
   output logic [DATA_W-1:0] readdata,
   output logic              readdatavalid
);
   logic [LAT:1]      vld_pipe;
   logic [DATA_W-1:0] dat_pipe [1:LAT];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         for (int i = 1; i <= LAT; i++) dat_pipe[i] <= '0;
      end else if (clken) begin
         vld_pipe[1] <= accept;
         dat_pipe[1] <= rd_word;
         for (int i = 2; i <= LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            dat_pipe[i] <= dat_pipe[i-1];
         end
      end
   end

   assign readdata      = dat_pipe[LAT];
   assign readdatavalid = vld_pipe[LAT] & clken;
endmodule

module onchip_memory_dp_ctrl #(
   parameter int                DATA_W       = 128,
   parameter int                DEPTH        = 32768,
   parameter int                ADDR_W       = 15,
   parameter int                READ_LATENCY = 1,
   parameter int                INIT_CLEAR   = 1,
   parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clken,
   onchip_memory_dp_ctrl_if.slave s1,
   onchip_memory_dp_ctrl_if.slave s2,
   output logic                  init_done
);
   localparam int                BYTES     = DATA_W / 8;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [31:0]       DEPTH_U   = 32'(DEPTH);

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
      $error("READ_LATENCY must be 1 or 2");
   end
   if ((DATA_W % 8) != 0) begin : g_bad_dw
      $error("DATA_W must be a multiple of 8");
   end
   if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_aw
      $error("ADDR_W too narrow for DEPTH");
   end

   typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_RUN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] init_addr, init_addr_nxt;
   logic              init_we;
   logic              wait_req;

   // ---------------- sequencer ----------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_RESET;
         init_addr <= '0;
      end else if (clken) begin
         state     <= state_nxt;
         init_addr <= init_addr_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      init_addr_nxt = init_addr;
      init_we       = 1'b0;
      case (state)
         ST_RESET: begin
            init_addr_nxt = '0;
            state_nxt     = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
         end
         ST_INIT: begin
            init_we = 1'b1;
            // leave on the same edge that writes the last word
            if (init_addr == LAST_ADDR) state_nxt = ST_RUN;
            else                        init_addr_nxt = init_addr + ADDR_W'(1);
         end
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_RESET;
      endcase
   end

   assign wait_req       = (state != ST_RUN) | ~clken;
   assign init_done      = (state == ST_RUN);
   assign s1.waitrequest = wait_req;
   assign s2.waitrequest = wait_req;

   // ---------------- accept decode ----------------
   logic wr1, wr2, rd1, rd2, inr1, inr2;

   assign wr1  = s1.chipselect & s1.write & ~wait_req;
   assign wr2  = s2.chipselect & s2.write & ~wait_req;
   assign rd1  = s1.chipselect & s1.read & ~s1.write & ~wait_req;
   assign rd2  = s2.chipselect & s2.read & ~s2.write & ~wait_req;
   assign inr1 = 32'(s1.address) < DEPTH_U;
   assign inr2 = 32'(s2.address) < DEPTH_U;

   // ---------------- storage ----------------
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_word1, rd_word2;

   // s2 lanes are assigned first so that s1 overrides on shared lanes when
   // both ports hit the same word.
   always_ff @(posedge clk) begin
      if (reset_n && clken) begin
         if (init_we) mem[init_addr] <= INIT_VALUE;
         for (int b = 0; b < BYTES; b++) begin
            if (wr2 && inr2 && s2.byteenable[b])
               mem[s2.address][b*8 +: 8] <= s2.writedata[b*8 +: 8];
            if (wr1 && inr1 && s1.byteenable[b])
               mem[s1.address][b*8 +: 8] <= s1.writedata[b*8 +: 8];
         end
      end
   end

   // Sampled into the read pipe on the accept edge, before that edge's writes land.
   assign rd_word1 = inr1 ? mem[s1.address] : '0;
   assign rd_word2 = inr2 ? mem[s2.address] : '0;

   onchip_memory_dp_rdpipe #(.DATA_W(DATA_W), .LAT(READ_LATENCY)) u_rd1 (
      .clk           (clk),
      .reset_n       (reset_n),
      .clken         (clken),
      .accept        (rd1),
      .rd_word       (rd_word1),
      .readdata      (s1.readdata),
      .readdatavalid (s1.readdatavalid)
   );

   onchip_memory_dp_rdpipe #(.DATA_W(DATA_W), .LAT(READ_LATENCY)) u_rd2 (
      .clk           (clk),
      .reset_n       (reset_n),
      .clken         (clken),
      .accept        (rd2),
      .rd_word       (rd_word2),
      .readdata      (s2.readdata),
      .readdatavalid (s2.readdatavalid)
   );
endmodule

// File: tb/tb_onchip_memory_dp_ctrl.sv
// Scoreboard bench: two DUTs (READ_LATENCY 1 and 2) share one stimulus stream.
// A reference model updates on each enabled edge and queues expected read
// returns with the enabled-cycle count at which each must appear; a separate
// negedge monitor pops and compares.
module tb_onchip_memory_dp_ctrl;
   localparam int          DW    = 32;
   localparam int          DEPTH = 12;
   localparam int          AW    = 4;
   localparam int          BE    = 4;
   localparam logic [31:0] IV    = 32'hA5A5A5A5;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clken = 1'b1;
   always #5 clk = ~clk;

   onchip_memory_dp_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) a1 (), a2 (), b1 (), b2 ();

   logic [AW-1:0] addr [2];
   logic [BE-1:0] be   [2];
   logic          cs   [2];
   logic          rd   [2];
   logic          wr   [2];
   logic [DW-1:0] wd   [2];
   logic          done_a, done_b;

   assign a1.address = addr[0]; assign a1.byteenable = be[0]; assign a1.chipselect = cs[0];
   assign a1.read = rd[0]; assign a1.write = wr[0]; assign a1.writedata = wd[0];
   assign a2.address = addr[1]; assign a2.byteenable = be[1]; assign a2.chipselect = cs[1];
   assign a2.read = rd[1]; assign a2.write = wr[1]; assign a2.writedata = wd[1];
   assign b1.address = addr[0]; assign b1.byteenable = be[0]; assign b1.chipselect = cs[0];
   assign b1.read = rd[0]; assign b1.write = wr[0]; assign b1.writedata = wd[0];
   assign b2.address = addr[1]; assign b2.byteenable = be[1]; assign b2.chipselect = cs[1];
   assign b2.read = rd[1]; assign b2.write = wr[1]; assign b2.writedata = wd[1];

   // index: 0 = A.s1, 1 = A.s2 (latency 1), 2 = B.s1, 3 = B.s2 (latency 2)
   logic [DW-1:0] rdata [4];
   logic          rdv   [4];
   logic          wreq  [4];
   assign rdata[0] = a1.readdata; assign rdv[0] = a1.readdatavalid; assign wreq[0] = a1.waitrequest;
   assign rdata[1] = a2.readdata; assign rdv[1] = a2.readdatavalid; assign wreq[1] = a2.waitrequest;
   assign rdata[2] = b1.readdata; assign rdv[2] = b1.readdatavalid; assign wreq[2] = b1.waitrequest;
   assign rdata[3] = b2.readdata; assign rdv[3] = b2.readdatavalid; assign wreq[3] = b2.waitrequest;

   onchip_memory_dp_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(1),
                           .INIT_CLEAR(1), .INIT_VALUE(IV)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .clken(clken), .s1(a1), .s2(a2), .init_done(done_a));

   onchip_memory_dp_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(2),
                           .INIT_CLEAR(1), .INIT_VALUE(IV)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .clken(clken), .s1(b1), .s2(b2), .init_done(done_b));

   // ---------------- checking helpers ----------------
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [DW-1:0] d;
      int            due;
   } exp_t;

   exp_t          sb [4][$];
   logic [DW-1:0] mm [16];
   int            ecnt  = 0;  // enabled edges seen
   int            m_cnt = 0;  // enabled edges since reset release
   bit            m_run = 1'b0;

   task automatic model_access();
      logic [DW-1:0] w;
      for (int p = 0; p < 2; p++) begin
         if (cs[p] && rd[p] && !wr[p]) begin
            w = (int'(addr[p]) < DEPTH) ? mm[addr[p]] : '0;
            sb[p].push_back('{w, ecnt + 1});
            sb[2+p].push_back('{w, ecnt + 2});
         end
      end
      // s2 applied before s1: s1 ends up owning lanes both ports enable
      for (int p = 1; p >= 0; p--) begin
         if (cs[p] && wr[p] && int'(addr[p]) < DEPTH)
            for (int b = 0; b < BE; b++)
               if (be[p][b]) mm[addr[p]][b*8 +: 8] = wd[p][b*8 +: 8];
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            m_cnt = 0;
            m_run = 1'b0;
            for (int i = 0; i < 4; i++) sb[i].delete();
            for (int i = 0; i < 16; i++) mm[i] = IV;
         end else if (clken) begin
            if (m_run) model_access();
            ecnt++;
            if (!m_run) begin
               m_cnt++;
               // one RESET cycle plus one sweep cycle per word
               if (m_cnt == 1 + DEPTH) m_run = 1'b1;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         chk1("init_done_a", done_a, m_run);
         chk1("init_done_b", done_b, m_run);
         for (int i = 0; i < 4; i++) begin
            bit ev;
            ev = clken && sb[i].size() > 0 && sb[i][0].due == ecnt;
            chk1($sformatf("waitrequest[%0d]", i), wreq[i], !m_run || !clken);
            chk1($sformatf("readdatavalid[%0d]", i), rdv[i], ev);
            if (ev) begin
               chk($sformatf("readdata[%0d]", i), rdata[i], sb[i][0].d);
               void'(sb[i].pop_front());
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      for (int p = 0; p < 2; p++) begin
         cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
         addr[p] = '0; be[p] = '0; wd[p] = '0;
      end
   endtask

   task automatic put(input int p, input bit r, input bit w, input int a,
                      input logic [BE-1:0] b, input logic [DW-1:0] d);
      cs[p] = 1'b1; rd[p] = r; wr[p] = w;
      addr[p] = a[AW-1:0]; be[p] = b; wd[p] = d;
   endtask

   task automatic reset_and_init();
      int cyc_a, cyc_b;
      idle();
      reset_n = 1'b0;
      step(3);
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk($sformatf("reset_readdata[%0d]", i), rdata[i], 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc_a = 0;
      cyc_b = 0;
      for (int c = 1; c <= 100 && (cyc_a == 0 || cyc_b == 0); c++) begin
         @(negedge clk);
         if (done_a && cyc_a == 0) cyc_a = c;
         if (done_b && cyc_b == 0) cyc_b = c;
      end
      chk("init_rise_cycle_a", cyc_a, DEPTH + 2);
      chk("init_rise_cycle_b", cyc_b, DEPTH + 2);
      step(1);
   endtask

   initial begin
      idle();
      reset_and_init();

      // sweep contents visible
      put(0, 1, 0, 7, '0, '0); step(1);
      put(1, 1, 0, 11, '0, '0); step(1); idle(); step(3);

      // writes then back-to-back reads
      put(0, 0, 1, 0, 4'hF, 32'd11); step(1);
      put(0, 0, 1, 1, 4'hF, 32'd22); step(1);
      put(0, 0, 1, 2, 4'hF, 32'd33); step(1);
      put(0, 1, 0, 0, '0, '0); step(1);
      put(0, 1, 0, 1, '0, '0); step(1);
      put(0, 1, 0, 2, '0, '0); step(1); idle(); step(4);

      // same-address collision over a zero word
      put(0, 0, 1, 5, 4'hF, 32'h0); step(1);
      put(0, 0, 1, 5, 4'b0011, 32'h11111111);
      put(1, 0, 1, 5, 4'b0110, 32'h22222222); step(1); idle();
      put(1, 1, 0, 5, '0, '0); step(1); idle(); step(3);

      // freeze during a pending read
      put(0, 1, 0, 1, '0, '0); step(1); idle();
      clken = 1'b0; step(3);
      clken = 1'b1; step(4);

      // out-of-range write/read, and both edges of the range
      put(0, 0, 1, 13, 4'hF, 32'hDEADBEEF); step(1);
      put(0, 1, 0, 13, '0, '0);
      put(1, 1, 0, DEPTH, '0, '0); step(1);
      put(0, 1, 0, DEPTH - 1, '0, '0); idle(); step(4);

      // read+write on one port, cross-port read-during-write, zero byteenable
      put(0, 1, 1, 4, 4'hF, 32'h44444444);
      put(1, 0, 1, 3, 4'h0, 32'hFFFFFFFF); step(1);
      put(0, 0, 1, 2, 4'hF, 32'h55555555);
      put(1, 1, 0, 2, '0, '0); step(1);
      put(0, 1, 0, 4, '0, '0);
      put(1, 1, 0, 3, '0, '0); step(1);
      put(0, 1, 0, 2, '0, '0); idle(); step(4);

      // randomized traffic
      repeat (400) begin
         for (int p = 0; p < 2; p++) begin
            cs[p]   = ($urandom_range(0, 7) != 0);
            rd[p]   = $urandom_range(0, 1) == 1;
            wr[p]   = ($urandom_range(0, 3) == 0);
            addr[p] = AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom_range(0, 15));
            be[p]   = BE'($urandom);
            wd[p]   = $urandom;
         end
         clken = ($urandom_range(0, 9) != 0);
         step(1);
      end
      idle(); clken = 1'b1; step(4);

      // pending read killed by reset, then reset mid-sweep with a freeze in it
      put(0, 1, 0, 3, '0, '0); step(1); idle();
      reset_n = 1'b0; step(2);
      reset_n = 1'b1; step(4);
      clken = 1'b0; step(2);
      clken = 1'b1; step(6);
      reset_and_init();
      put(0, 1, 0, 5, '0, '0);
      put(1, 1, 0, 9, '0, '0); step(1); idle(); step(4);

      chk("scoreboard_drained", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
